// File: rtl/seed_a_row_feeder_pkg.sv
// Shared constants and types for the seed-A row feeder: command width,
// message word width and the FSM state encoding.
package seed_a_row_feeder_pkg;

    localparam int SeedAFeederCMD_SIZE = 32;
    localparam int WordW               = 64;
    localparam int IdxW                = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        S0   = 3'd2,
        S1   = 3'd3,
        TAIL = 3'd4
    } state_e;

endpackage

// File: rtl/seed_a_row_feeder_if.sv
// Valid/ready stream channel used for the command, replay-request, seed and
// message ports. isLast/isRowLast are side bits travelling with data.
interface seed_a_row_feeder_if #(
    parameter int W = 64
);
    logic [W-1:0] data;
    logic         isReady;
    logic         canReceive;
    logic         isLast;
    logic         isRowLast;

    modport master (output data, isReady, isLast, isRowLast, input canReceive);
    modport slave  (input data, isReady, isLast, isRowLast, output canReceive);
endinterface

// File: rtl/seed_a_row_feeder_stream_reg64.sv
// One-entry output register with isLast/isRowLast side bits. It can be loaded
// when empty or when its current word is being drained in the same cycle.
module stream_reg64
    import seed_a_row_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WordW-1:0] data_in,
    input  logic             last_in,
    input  logic             row_last_in,
    input  logic             can_receive,
    output logic [WordW-1:0] data,
    output logic             valid,
    output logic             is_last,
    output logic             is_row_last,
    output logic             free
);

    assign free = !valid || can_receive;

    // NOTE: the data path is reset too, because out=0 is a visible reset value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data        <= '0;
            valid       <= 1'b0;
            is_last     <= 1'b0;
            is_row_last <= 1'b0;
        end else if (load) begin
            data        <= data_in;
            valid       <= 1'b1;
            is_last     <= last_in;
            is_row_last <= row_last_in;
        end else if (valid && can_receive) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/seed_a_row_feeder.sv
// Replays seedA from storage once per row of A and emits {seedA, idx} as
// three 64-bit words per row to the SHAKE absorber.
module seed_a_row_feeder
    import seed_a_row_feeder_pkg::*;
#(
    parameter int RowCountMax = 1344
) (
    input  logic                       clk,
    input  logic                       rst,
    seed_a_row_feeder_if.slave         cmd,
    seed_a_row_feeder_if.master        seed_cmd,
    seed_a_row_feeder_if.slave         seed,
    seed_a_row_feeder_if.master        out,
    output logic                       err
);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [IdxW-1:0]  remaining_q, remaining_d;
    logic [IdxW-1:0]  carry_q, carry_d;
    logic             err_d;

    logic             load;
    logic [WordW-1:0] load_data;
    logic             load_last;
    logic             load_row_last;
    logic             stage_free;

    assign seed_cmd.data      = 1'b1;
    assign seed_cmd.isLast    = 1'b0;
    assign seed_cmd.isRowLast = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            carry_q     <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            carry_q     <= carry_d;
            err         <= err_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        remaining_d         = remaining_q;
        carry_d             = carry_q;
        err_d               = err;
        cmd.canReceive      = 1'b0;
        seed_cmd.isReady    = 1'b0;
        seed.canReceive     = 1'b0;
        load                = 1'b0;
        load_data           = '0;
        load_last           = 1'b0;
        load_row_last       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd.canReceive = 1'b1;
                if (cmd.isReady) begin
                    idx_d       = cmd.data[31:16];
                    remaining_d = cmd.data[15:0];
                    if (cmd.data[15:0] != '0) state_d = REQ;
                end
            end
            REQ: begin
                seed_cmd.isReady = 1'b1;
                if (seed_cmd.canReceive) state_d = S0;
            end
            S0: begin
                seed.canReceive = stage_free;
                if (seed.isReady && stage_free) begin
                    load      = 1'b1;
                    load_data = {seed.data[47:0], idx_q};
                    carry_d   = seed.data[63:48];
                    if (seed.isLast) err_d = 1'b1;
                    state_d   = S1;
                end
            end
            S1: begin
                seed.canReceive = stage_free;
                if (seed.isReady && stage_free) begin
                    load      = 1'b1;
                    load_data = {seed.data[47:0], carry_q};
                    carry_d   = seed.data[63:48];
                    if (!seed.isLast) err_d = 1'b1;
                    state_d   = TAIL;
                end
            end
            TAIL: begin
                if (stage_free) begin
                    load          = 1'b1;
                    load_data     = {48'b0, carry_q};
                    load_last     = 1'b1;
                    load_row_last = (remaining_q == 16'd1);
                    remaining_d   = remaining_q - 16'd1;
                    idx_d         = idx_q + 16'd1;
                    state_d       = (remaining_q == 16'd1) ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    stream_reg64 u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data_in     (load_data),
        .last_in     (load_last),
        .row_last_in (load_row_last),
        .can_receive (out.canReceive),
        .data        (out.data),
        .valid       (out.isReady),
        .is_last     (out.isLast),
        .is_row_last (out.isRowLast),
        .free        (stage_free)
    );

    a_row_count_max : assert property (@(posedge clk) disable iff (!rst)
        (cmd.isReady && cmd.canReceive) |-> (int'(cmd.data[15:0]) <= RowCountMax));

endmodule
